// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RV32I controller: states, opcodes,
// immediate formats, ALU operation codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StJalrLink = 4'd12
    } state_e;

    localparam state_e ResetState = StFetch;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSltu = 4'b0110;
    localparam logic [3:0] AluSll  = 4'b0111;
    localparam logic [3:0] AluSrl  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1001;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic       AdrPc     = 1'b0;
    localparam logic       AdrAluOut = 1'b1;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARegA  = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBWd   = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        logic [2:0] imm;
        imm = ImmI;
        case (op)
            OpStore:         imm = ImmS;
            OpBranch:        imm = ImmB;
            OpJal:           imm = ImmJ;
            OpLui, OpAuipc:  imm = ImmU;
            default:         imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] onto an ALU operation code.
module multicycle_controller_aludec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        case (alu_op_i)
            AluOpAdd: alu_control_o = AluAdd;
            AluOpSub: alu_control_o = AluSub;
            default: begin
                case (funct3_i)
                    // Only R-type uses bit 30 as add/sub; for OP-IMM it is immediate data.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
                    3'b001:  alu_control_o = AluSll;
                    3'b010:  alu_control_o = AluSlt;
                    3'b011:  alu_control_o = AluSltu;
                    3'b100:  alu_control_o = AluXor;
                    3'b101:  alu_control_o = funct7b5_i ? AluSra : AluSrl;
                    3'b110:  alu_control_o = AluOr;
                    default: alu_control_o = AluAnd;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath. Defining MC_MEM_READY_EN adds a
// mem_ready input that stalls FETCH, MEMREAD and MEMWRITE until memory responds.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef MC_MEM_READY_EN
    input  logic       mem_ready,
`endif
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       IllegalInstr
);

    state_e     state_q, state_d;
    logic       mem_rdy;
    logic [1:0] alu_op;
    logic [3:0] dec_ctrl;
    logic [3:0] br_ctrl;
    logic       br_taken;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;

`ifdef MC_MEM_READY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        alu_op = AluOpAdd;
        if (state_q == StExecR || (state_q == StExecI && op == OpImm)) begin
            alu_op = AluOpFunct;
        end
    end

    multicycle_controller_aludec u_aludec (
        .alu_op_i      (alu_op),
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (dec_ctrl)
    );

    // Zero reflects the compare result: SUB for equality, SLT/SLTU give 1 (non-zero) if less.
    always_comb begin
        br_ctrl  = AluSub;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  begin br_ctrl = AluSub;  br_taken = Zero;  end
            3'b001:  begin br_ctrl = AluSub;  br_taken = !Zero; end
            3'b100:  begin br_ctrl = AluSlt;  br_taken = !Zero; end
            3'b101:  begin br_ctrl = AluSlt;  br_taken = Zero;  end
            3'b110:  begin br_ctrl = AluSltu; br_taken = !Zero; end
            3'b111:  begin br_ctrl = AluSltu; br_taken = Zero;  end
            default: begin br_ctrl = AluSub;  br_taken = 1'b0;  end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = AdrPc;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = ResAluOut;
        src_a      = SrcAPc;
        src_b      = SrcBWd;
        imm_src    = ImmI;
        alu_ctrl   = AluAdd;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                adr_src    = AdrPc;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
                src_a      = SrcAPc;
                src_b      = SrcBFour;
                result_src = ResAluResult;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBImm;
                imm_src = imm_src_for(op);
                case (op)
                    OpLoad, OpStore:        state_d = StMemAdr;
                    OpR:                    state_d = StExecR;
                    OpImm, OpLui, OpAuipc:  state_d = StExecI;
                    OpBranch:               state_d = StBranch;
                    OpJal:                  state_d = StJal;
                    OpJalr:                 state_d = StJalr;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                src_a   = SrcARegA;
                src_b   = SrcBImm;
                imm_src = (op == OpStore) ? ImmS : ImmI;
                state_d = (op == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src = AdrAluOut;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src   = AdrAluOut;
                mem_write = 1'b1;
                if (mem_rdy) state_d = StFetch;
            end
            StExecR: begin
                src_a    = SrcARegA;
                src_b    = SrcBWd;
                alu_ctrl = dec_ctrl;
                state_d  = StAluWb;
            end
            StExecI: begin
                src_b    = SrcBImm;
                alu_ctrl = dec_ctrl;
                case (op)
                    OpLui:   begin src_a = SrcAZero;  imm_src = ImmU; end
                    OpAuipc: begin src_a = SrcAOldPc; imm_src = ImmU; end
                    default: begin src_a = SrcARegA;  imm_src = ImmI; end
                endcase
                state_d = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                src_a      = SrcARegA;
                src_b      = SrcBWd;
                alu_ctrl   = br_ctrl;
                result_src = ResAluOut;
                pc_write   = br_taken;
                state_d    = StFetch;
            end
            StJal: begin
                // ALUOut holds the target computed in DECODE; ALU forms the link address.
                result_src = ResAluOut;
                pc_write   = 1'b1;
                src_a      = SrcAOldPc;
                src_b      = SrcBFour;
                state_d    = StAluWb;
            end
            StJalr: begin
                src_a      = SrcARegA;
                src_b      = SrcBImm;
                imm_src    = ImmI;
                result_src = ResAluResult;
                pc_write   = 1'b1;
                state_d    = StJalrLink;
            end
            StJalrLink: begin
                src_a   = SrcAOldPc;
                src_b   = SrcBFour;
                state_d = StAluWb;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset forces every output low so no write can land during the reset cycle.
    assign PCWrite      = !reset && pc_write;
    assign AdrSrc       = !reset && adr_src;
    assign MemWrite     = !reset && mem_write;
    assign IRWrite      = !reset && ir_write;
    assign RegWrite     = !reset && reg_write;
    assign IllegalInstr = !reset && illegal;
    assign ResultSrc    = reset ? 2'b00 : result_src;
    assign ALUSrcA      = reset ? 2'b00 : src_a;
    assign ALUSrcB      = reset ? 2'b00 : src_b;
    assign ImmSrc       = reset ? 3'b000 : imm_src;
    assign ALUControl   = reset ? 4'b0000 : alu_ctrl;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; covers the mem_ready stall
// checks as well when MC_MEM_READY_EN is defined.
module tb_multicycle_controller;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_SLT  = 4'b0101;
    localparam logic [3:0] A_SLTU = 4'b0110;
    localparam logic [3:0] A_SRA  = 4'b1001;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
`ifdef MC_MEM_READY_EN
    logic       mem_ready;
`endif

    int n_checks;
    int n_errors;

    logic [18:0] outs;
    logic [18:0] fetch_v;
    logic [18:0] zero_v;

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
`ifdef MC_MEM_READY_EN
        .mem_ready    (mem_ready),
`endif
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .IllegalInstr (IllegalInstr)
    );

    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ImmSrc, ALUControl, IllegalInstr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Settle, compare the output vector, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [18:0] e);
        #1;
        check(tag, {13'b0, outs}, {13'b0, e});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] dec_v(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, A_ADD, 0);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        fetch_v  = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, A_ADD, 0);
        zero_v   = '0;
        reset    = 1'b1;
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
`ifdef MC_MEM_READY_EN
        mem_ready = 1'b1;
`endif
        #1;
        check("rst_t0", {13'b0, outs}, 32'h0);
        @(posedge clk); #1;
        cyc("rst_c1", zero_v);
        cyc("rst_c2", zero_v);
        reset = 1'b0;

        // add, then sub
        cyc("add_fetch", fetch_v);
        cyc("add_dec", dec_v(3'b000));
        cyc("add_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD, 0));
        cyc("add_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        funct7b5 = 1'b1;
        cyc("sub_fetch", fetch_v);
        cyc("sub_dec", dec_v(3'b000));
        cyc("sub_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_SUB, 0));
        cyc("sub_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));

        // addi with imm bit 30 set must stay ADD; srai decodes to SRA
        op = 7'b0010011;
        cyc("addi_fetch", fetch_v);
        cyc("addi_dec", dec_v(3'b000));
        cyc("addi_execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, A_ADD, 0));
        cyc("addi_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        funct3 = 3'b101;
        cyc("srai_fetch", fetch_v);
        cyc("srai_dec", dec_v(3'b000));
        cyc("srai_execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, A_SRA, 0));
        cyc("srai_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        funct3 = 3'b000; funct7b5 = 1'b0;

        // lui / auipc
        op = 7'b0110111;
        cyc("lui_fetch", fetch_v);
        cyc("lui_dec", dec_v(3'b100));
        cyc("lui_execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, A_ADD, 0));
        cyc("lui_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        op = 7'b0010111;
        cyc("auipc_fetch", fetch_v);
        cyc("auipc_dec", dec_v(3'b100));
        cyc("auipc_execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, A_ADD, 0));
        cyc("auipc_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));

        // lw: 5 cycles
        op = 7'b0000011; funct3 = 3'b010;
        cyc("lw_fetch", fetch_v);
        cyc("lw_dec", dec_v(3'b000));
        cyc("lw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, A_ADD, 0));
        cyc("lw_memread", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        cyc("lw_memwb", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, A_ADD, 0));

        // sw: 4 cycles, MemWrite only in cycle 4
        op = 7'b0100011;
        cyc("sw_fetch", fetch_v);
        cyc("sw_dec", dec_v(3'b001));
        cyc("sw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, A_ADD, 0));
        cyc("sw_memwrite", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));

        // branches
        op = 7'b1100011; funct3 = 3'b001; Zero = 1'b0;
        cyc("bne_t_fetch", fetch_v);
        cyc("bne_t_dec", dec_v(3'b010));
        cyc("bne_t_br", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_SUB, 0));
        Zero = 1'b1;
        cyc("bne_nt_fetch", fetch_v);
        cyc("bne_nt_dec", dec_v(3'b010));
        cyc("bne_nt_br", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_SUB, 0));
        funct3 = 3'b100; Zero = 1'b0;
        cyc("blt_fetch", fetch_v);
        cyc("blt_dec", dec_v(3'b010));
        cyc("blt_br", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_SLT, 0));
        funct3 = 3'b111; Zero = 1'b1;
        cyc("bgeu_fetch", fetch_v);
        cyc("bgeu_dec", dec_v(3'b010));
        cyc("bgeu_br", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_SLTU, 0));
        funct3 = 3'b010; Zero = 1'b1;
        cyc("b010_fetch", fetch_v);
        cyc("b010_dec", dec_v(3'b010));
        #1;
        check("b010_pcw", {31'b0, PCWrite}, 32'd0);
        @(posedge clk); #1;
        funct3 = 3'b000;

        // jal: 4 cycles
        op = 7'b1101111;
        cyc("jal_fetch", fetch_v);
        cyc("jal_dec", dec_v(3'b011));
        cyc("jal_jal", mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, A_ADD, 0));
        cyc("jal_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));

        // jalr: 5 cycles
        op = 7'b1100111;
        cyc("jalr_fetch", fetch_v);
        cyc("jalr_dec", dec_v(3'b000));
        cyc("jalr_jalr", mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, A_ADD, 0));
        cyc("jalr_link", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, A_ADD, 0));
        cyc("jalr_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));

        // illegal opcode: 2 cycles, pulse in DECODE, no writes
        op = 7'b1111111;
        cyc("ill_fetch", fetch_v);
        cyc("ill_dec", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, A_ADD, 1));
        op = 7'b0110011;
        cyc("ill_next_fetch", fetch_v);
        cyc("ill_next_dec", dec_v(3'b000));
        cyc("ill_next_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD, 0));
        cyc("ill_next_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));

`ifdef MC_MEM_READY_EN
        // FETCH stalls with IRWrite/PCWrite low until mem_ready
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("rdy_fetch_stall", mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, A_ADD, 0));
        end
        mem_ready = 1'b1;
        cyc("rdy_fetch_go", fetch_v);
        cyc("rdy_dec", dec_v(3'b000));
        cyc("rdy_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD, 0));
        cyc("rdy_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        // MEMWRITE stall keeps MemWrite high
        op = 7'b0100011;
        cyc("rdy_sw_fetch", fetch_v);
        cyc("rdy_sw_dec", dec_v(3'b001));
        cyc("rdy_sw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, A_ADD, 0));
        mem_ready = 1'b0;
        cyc("rdy_sw_stall0", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        cyc("rdy_sw_stall1", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
        mem_ready = 1'b1;
        cyc("rdy_sw_done", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0));
`endif

        // reset asserted during MEMWRITE suppresses the write and returns to FETCH
        op = 7'b0100011;
        cyc("rsw_fetch", fetch_v);
        cyc("rsw_dec", dec_v(3'b001));
        cyc("rsw_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, A_ADD, 0));
        reset = 1'b1;
        cyc("rsw_memwrite_rst", zero_v);
        reset = 1'b0;
        cyc("rsw_after_fetch", fetch_v);
        cyc("rsw_after_dec", dec_v(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
